bitonic_unloader: RTL and testbench
===================================

# bitonic_unloader

Output end of the bitonic sorting network: captures each fully sorted parallel frame leaving the last compare-swap stage and streams it out one element per cycle under valid/ready backpressure. The network itself is a fixed-latency pipeline that cannot stall, so this block provides two-frame ping-pong buffering. It also raises a sticky error when a frame arrives with no free buffer.

## Interface
Parameters:
- N_ELEM, 8: elements per frame; power of two, at least 2.
- REVERSE, 0: 0 streams element 0 first; 1 streams element N_ELEM-1 first, which turns an ascending frame into a descending stream.
- Element width is the global `DATA_WIDTH macro; it is not a parameter.

Ports:
- clk, in, 1: single clock; all state updates on the rising edge.
- rst_n, in, 1: asynchronous, active-low reset.
- frame_valid, in, 1: sorted frame present on frame_data this cycle.
- frame_data, in, N_ELEM*`DATA_WIDTH: element i sits at bits [i*`DATA_WIDTH +: `DATA_WIDTH].
- frame_ready, out, 1: a free slot exists; the frame is accepted on an edge where frame_valid && frame_ready.
- out_valid, out, 1: out_data is valid.
- out_ready, in, 1: downstream accepts; the element transfers on an edge where out_valid && out_ready.
- out_data, out, `DATA_WIDTH: current stream element.
- out_idx, out, $clog2(N_ELEM): position of the current element in the stream, 0..N_ELEM-1.
- out_last, out, 1: high with the final element of a frame.
- err_overflow, out, 1: sticky; set when frame_valid && !frame_ready; cleared only by reset.

## Operation
State:
- Two frame slots.
- wr_ptr, 1 bit.
- rd_ptr, 1 bit.
- count, 0..2.
- elem_cnt, $clog2(N_ELEM) bits.
- err_overflow flag.

Reset values:
- count=0, wr_ptr=0, rd_ptr=0, elem_cnt=0, err_overflow=0.
- Therefore out_valid=0, out_last=0, out_idx=0, out_data=0 (masked while invalid), frame_ready=1.

Behaviour:
- frame_ready = (count != 0b10). It depends on registered state only, never combinationally on out_ready.
- Accept: write the whole frame into slot[wr_ptr], toggle wr_ptr, increment count.
- Drop: when frame_valid && !frame_ready, the frame is discarded, no state other than err_overflow changes, and err_overflow is set.
- out_valid = (count != 0).
- out_idx = elem_cnt.
- out_data = slot[rd_ptr][REVERSE ? N_ELEM-1-elem_cnt : elem_cnt].
- out_last = out_valid && (elem_cnt == N_ELEM-1).
- Transfer, non-last: elem_cnt increments.
- Transfer, last: elem_cnt wraps to 0, rd_ptr toggles, count decrements, freeing the slot.
- Accept and last-transfer on the same edge: count is unchanged and both pointers toggle. With count=2 the accept is still refused that cycle, because frame_ready was already low.
- While out_valid && !out_ready: out_data, out_idx and out_last hold stable.
- Reset mid-frame: all buffered data is discarded. out_valid drops asynchronously with rst_n assertion.

## Timing
- Latency: a frame accepted on edge k into an empty block gives out_valid=1 with element 0 in the cycle after edge k.
- Throughput: N_ELEM cycles per frame with out_ready held high. Back-to-back frames stream with no bubble; out_idx goes N_ELEM-1 then 0 on consecutive cycles.
- Sustained frame rate: upstream may present one frame every N_ELEM cycles without overflow. A burst of 2 frames is absorbed at any time when the block is empty.
- out_data path: registers followed by an N_ELEM:1 mux only; no arithmetic.

## Structure
- Shared package bitonic_pkg:
  - elem_t typedef, logic [`DATA_WIDTH-1:0];
  - frame_t, an array of elem_t, shared with the network top level.
- No sub-module needed. The slots are a 2-entry array of frame_t inside this module.
- The top-level sorter instantiates this block after the final compare-swap stage. Its frame_valid comes from a valid shift register matching the network depth.

## Test plan
All scenarios use N_ELEM=4 and `DATA_WIDTH=16.
- Reset and single frame:
  - Release rst_n, then present frame {1,5,9,12} (elem0=1) for one cycle, out_ready=1.
  - Required: out_data 1,5,9,12 on the 4 cycles after acceptance; out_idx 0..3; out_last only with 12.
- REVERSE:
  - REVERSE=1, same frame.
  - Required: stream 12,9,5,1, with out_last on 1.
- Backpressure:
  - out_ready=0 for 3 cycles on element 5.
  - Required: out_data=5 and out_idx=1 held stable; stream then resumes with 9.
- Two buffered frames, then overflow:
  - out_ready=0; present frames A, B, C on consecutive cycles.
  - Required: A and B accepted; frame_ready=0 when C arrives; C dropped; err_overflow=1 and stays 1.
  - Then out_ready=1. Required: exactly 8 elements, A then B, with no bubble.
- Simultaneous accept and last:
  - With count=1, present a new frame on the same edge as the last-element transfer.
  - Required: accepted; count stays 1; the next element is element 0 of the new frame.
- Async reset mid-stream:
  - Assert rst_n low during out_idx=2.
  - Required: out_valid=0 immediately; frame_ready=1 and err_overflow=0 after release; no stale elements appear afterwards.

Source files
------------

// File: rtl/bitonic_pkg.sv
// Shared types for the bitonic sorting network and its output unloader.
// Element width comes from the global DATA_WIDTH macro (defaults to 16 here
// so the package elaborates standalone).
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

package bitonic_pkg;

  // One sortable element.
  typedef logic [`DATA_WIDTH-1:0] elem_t;

  // Default network width. A frame is an element array, element 0 in the low bits.
  // Blocks parameterised on N_ELEM build their own frame type of the same shape.
  localparam int FRAME_ELEMS = 8;
  typedef elem_t [FRAME_ELEMS-1:0] frame_t;

endpackage

// File: rtl/bitonic_unloader_if.sv
// Handshake bundle around the unloader: the sorted-frame input from the
// last compare-swap stage and the one-element-per-cycle output stream.
// Ports (slave = unloader side):
//   frame_valid/frame_data -> in,  frame_ready -> out
//   out_valid/out_data/out_idx/out_last -> out,  out_ready -> in
interface bitonic_unloader_if
  import bitonic_pkg::*;
#(
  parameter int N_ELEM = 8
) ();

  localparam int IW = $clog2(N_ELEM);

  // Frame ingress (network cannot stall, frame_ready only flags a drop).
  logic                          frame_valid;
  logic [N_ELEM*`DATA_WIDTH-1:0] frame_data;
  logic                          frame_ready;

  // Element egress, valid/ready.
  logic                          out_valid;
  logic                          out_ready;
  elem_t                         out_data;
  logic [IW-1:0]                 out_idx;
  logic                          out_last;

  // The unloader itself.
  modport slave (
    input  frame_valid, frame_data, out_ready,
    output frame_ready, out_valid, out_data, out_idx, out_last
  );

  // Upstream network plus downstream consumer.
  modport master (
    output frame_valid, frame_data, out_ready,
    input  frame_ready, out_valid, out_data, out_idx, out_last
  );

endinterface

// File: rtl/bitonic_unloader.sv
// Purpose: ping-pong buffer for sorted frames, streams one element per cycle.
// Latency: frame accepted on edge k -> element 0 valid in the cycle after edge k.
// Backpressure: out_ready stalls the stream; frame_ready low only when both
//   slots are full, and a frame offered then is dropped (sticky err_overflow).
// Ports: clk, rst_n (async active-low), bus (slave modport), err_overflow.
module bitonic_unloader
  import bitonic_pkg::*;
#(
  parameter int N_ELEM  = 8,      // power of two, >= 2
  parameter bit REVERSE = 1'b0    // 1: stream element N_ELEM-1 first
) (
  input  logic              clk,
  input  logic              rst_n,
  bitonic_unloader_if.slave bus,
  output logic              err_overflow
);

  localparam int            IW       = $clog2(N_ELEM);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_ELEM - 1);

  typedef elem_t [N_ELEM-1:0] slot_t;

  // Storage and control state.
  slot_t         slot_q [2];
  logic          wr_ptr_q, wr_ptr_d;
  logic          rd_ptr_q, rd_ptr_d;
  logic [1:0]    count_q, count_d;
  logic [IW-1:0] elem_cnt_q, elem_cnt_d;
  logic          err_q, err_d;

  // Handshake decode.
  logic          frame_ready;
  logic          out_valid;
  logic          out_last;
  logic          accept;
  logic          xfer;
  logic          last_xfer;
  logic [IW-1:0] rd_sel;

  // Ready depends on stored occupancy only, so the network never sees a
  // combinational path from out_ready.
  assign frame_ready = (count_q != 2'd2);
  assign out_valid   = (count_q != 2'd0);
  assign out_last    = out_valid && (elem_cnt_q == LAST_IDX);

  assign accept      = bus.frame_valid && frame_ready;
  assign xfer        = out_valid && bus.out_ready;
  assign last_xfer   = xfer && out_last;

  // N_ELEM is a power of two, so N_ELEM-1-i is just the bitwise inverse:
  // the read path stays a pure mux with no subtractor.
  assign rd_sel      = REVERSE ? ~elem_cnt_q : elem_cnt_q;

  assign bus.frame_ready = frame_ready;
  assign bus.out_valid   = out_valid;
  assign bus.out_idx     = elem_cnt_q;
  assign bus.out_last    = out_last;
  // Masked while idle so stale slot contents never leak onto the bus.
  assign bus.out_data    = out_valid ? slot_q[rd_ptr_q][rd_sel] : '0;
  assign err_overflow    = err_q;

  // Next-state logic.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    elem_cnt_d = elem_cnt_q;
    err_d      = err_q;

    if (accept) begin
      wr_ptr_d = ~wr_ptr_q;
    end

    if (xfer) begin
      if (out_last) begin
        elem_cnt_d = '0;
        rd_ptr_d   = ~rd_ptr_q;
      end else begin
        elem_cnt_d = elem_cnt_q + 1'b1;
      end
    end

    // Accept and slot release on the same edge cancel out.
    if (accept && !last_xfer) begin
      count_d = count_q + 2'd1;
    end else if (!accept && last_xfer) begin
      count_d = count_q - 2'd1;
    end

    if (bus.frame_valid && !frame_ready) begin
      err_d = 1'b1;
    end
  end

  // Control state; async reset discards any buffered frames at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      elem_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      elem_cnt_q <= elem_cnt_d;
      err_q      <= err_d;
    end
  end

  // Frame slots carry no reset: contents are only observable while count
  // says the slot is occupied.
  always_ff @(posedge clk) begin
    if (accept) begin
      slot_q[wr_ptr_q] <= slot_t'(bus.frame_data);
    end
  end

endmodule

// File: tb/tb_bitonic_unloader.sv
// Directed bench for bitonic_unloader with N_ELEM=4, 16-bit elements.
// One forward instance carries most scenarios; a REVERSE=1 instance checks
// descending streaming.
module tb_bitonic_unloader;

  localparam int NE = 4;

  logic clk;
  logic rst_n;
  logic err_fwd;
  logic err_rev;

  int n_run;
  int n_fail;

  bitonic_unloader_if #(.N_ELEM(NE)) fwd_if ();
  bitonic_unloader_if #(.N_ELEM(NE)) rev_if ();

  bitonic_unloader #(.N_ELEM(NE), .REVERSE(1'b0)) u_fwd (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (fwd_if),
    .err_overflow (err_fwd)
  );

  bitonic_unloader #(.N_ELEM(NE), .REVERSE(1'b1)) u_rev (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (rev_if),
    .err_overflow (err_rev)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NE*16-1:0] pack4(input logic [15:0] e0, input logic [15:0] e1,
                                             input logic [15:0] e2, input logic [15:0] e3);
    return {e3, e2, e1, e0};
  endfunction

  // Check the forward stream element at position i against exp.
  task automatic chk_fwd(input string tag, input int i, input logic [15:0] exp, input bit last);
    chk({tag, "_vld"}, fwd_if.out_valid, 1);
    chk({tag, "_dat"}, fwd_if.out_data, exp);
    chk({tag, "_idx"}, fwd_if.out_idx, i % NE);
    chk({tag, "_last"}, fwd_if.out_last, last);
  endtask

  logic [15:0] exp_q [$];

  initial begin
    n_run  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    fwd_if.frame_valid = 1'b0;
    fwd_if.frame_data  = '0;
    fwd_if.out_ready   = 1'b0;
    rev_if.frame_valid = 1'b0;
    rev_if.frame_data  = '0;
    rev_if.out_ready   = 1'b0;

    // ---- reset state ----
    #1;
    chk("rst_vld",   fwd_if.out_valid, 0);
    chk("rst_last",  fwd_if.out_last, 0);
    chk("rst_idx",   fwd_if.out_idx, 0);
    chk("rst_dat",   fwd_if.out_data, 0);
    chk("rst_frdy",  fwd_if.frame_ready, 1);
    chk("rst_err",   err_fwd, 0);
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("rel_vld",  fwd_if.out_valid, 0);
    chk("rel_frdy", fwd_if.frame_ready, 1);

    // ---- single frame, forward ----
    fwd_if.frame_valid = 1'b1;
    fwd_if.frame_data  = pack4(16'd1, 16'd5, 16'd9, 16'd12);
    fwd_if.out_ready   = 1'b1;
    cyc();
    fwd_if.frame_valid = 1'b0;
    exp_q = '{16'd1, 16'd5, 16'd9, 16'd12};
    for (int i = 0; i < NE; i++) begin
      chk_fwd("single", i, exp_q[i], i == NE - 1);
      cyc();
    end
    chk("single_end_vld", fwd_if.out_valid, 0);

    // ---- REVERSE=1 ----
    rev_if.frame_valid = 1'b1;
    rev_if.frame_data  = pack4(16'd1, 16'd5, 16'd9, 16'd12);
    rev_if.out_ready   = 1'b1;
    cyc();
    rev_if.frame_valid = 1'b0;
    exp_q = '{16'd12, 16'd9, 16'd5, 16'd1};
    for (int i = 0; i < NE; i++) begin
      chk("rev_vld",  rev_if.out_valid, 1);
      chk("rev_dat",  rev_if.out_data, exp_q[i]);
      chk("rev_idx",  rev_if.out_idx, i);
      chk("rev_last", rev_if.out_last, i == NE - 1);
      cyc();
    end
    chk("rev_end_vld", rev_if.out_valid, 0);

    // ---- backpressure on element 5 ----
    fwd_if.frame_valid = 1'b1;
    fwd_if.frame_data  = pack4(16'd1, 16'd5, 16'd9, 16'd12);
    cyc();
    fwd_if.frame_valid = 1'b0;
    chk_fwd("bp0", 0, 16'd1, 0);
    cyc();
    chk_fwd("bp1", 1, 16'd5, 0);
    fwd_if.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk_fwd("bp_hold", 1, 16'd5, 0);
    end
    fwd_if.out_ready = 1'b1;
    cyc();
    chk_fwd("bp2", 2, 16'd9, 0);
    cyc();
    chk_fwd("bp3", 3, 16'd12, 1);
    cyc();
    chk("bp_end_vld", fwd_if.out_valid, 0);

    // ---- two buffered frames, then overflow ----
    fwd_if.out_ready   = 1'b0;
    chk("ovf_err_pre", err_fwd, 0);
    fwd_if.frame_valid = 1'b1;
    fwd_if.frame_data  = pack4(16'd10, 16'd11, 16'd12, 16'd13);   // A
    cyc();
    chk("ovf_frdy_a", fwd_if.frame_ready, 1);
    fwd_if.frame_data  = pack4(16'd20, 16'd21, 16'd22, 16'd23);   // B
    cyc();
    chk("ovf_frdy_c", fwd_if.frame_ready, 0);
    chk("ovf_err_b", err_fwd, 0);
    fwd_if.frame_data  = pack4(16'd90, 16'd91, 16'd92, 16'd93);   // C, dropped
    cyc();
    fwd_if.frame_valid = 1'b0;
    chk("ovf_err_set", err_fwd, 1);
    cyc();
    chk("ovf_err_sticky", err_fwd, 1);
    chk("ovf_hold_dat", fwd_if.out_data, 16'd10);
    fwd_if.out_ready = 1'b1;
    exp_q = '{16'd10, 16'd11, 16'd12, 16'd13, 16'd20, 16'd21, 16'd22, 16'd23};
    for (int i = 0; i < 2 * NE; i++) begin
      chk_fwd("ovf_stream", i, exp_q[i], (i % NE) == NE - 1);
      cyc();
    end
    chk("ovf_end_vld", fwd_if.out_valid, 0);
    chk("ovf_err_end", err_fwd, 1);

    // ---- simultaneous accept and last transfer ----
    fwd_if.frame_valid = 1'b1;
    fwd_if.frame_data  = pack4(16'd30, 16'd31, 16'd32, 16'd33);   // D
    cyc();
    fwd_if.frame_valid = 1'b0;
    chk_fwd("sim_d0", 0, 16'd30, 0);
    cyc();
    cyc();
    cyc();
    chk_fwd("sim_d3", 3, 16'd33, 1);
    fwd_if.frame_valid = 1'b1;
    fwd_if.frame_data  = pack4(16'd40, 16'd41, 16'd42, 16'd43);   // E
    chk("sim_frdy", fwd_if.frame_ready, 1);
    cyc();
    fwd_if.frame_valid = 1'b0;
    chk("sim_frdy_after", fwd_if.frame_ready, 1);
    exp_q = '{16'd40, 16'd41, 16'd42, 16'd43};
    for (int i = 0; i < NE; i++) begin
      chk_fwd("sim_e", i, exp_q[i], i == NE - 1);
      cyc();
    end
    chk("sim_end_vld", fwd_if.out_valid, 0);

    // ---- async reset mid-stream ----
    fwd_if.frame_valid = 1'b1;
    fwd_if.frame_data  = pack4(16'd50, 16'd51, 16'd52, 16'd53);   // F
    cyc();
    fwd_if.frame_valid = 1'b0;
    cyc();
    cyc();
    chk_fwd("ars_f2", 2, 16'd52, 0);
    rst_n = 1'b0;
    #1;
    chk("ars_vld_now", fwd_if.out_valid, 0);
    chk("ars_dat_now", fwd_if.out_data, 0);
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("ars_frdy", fwd_if.frame_ready, 1);
    chk("ars_err",  err_fwd, 0);
    for (int i = 0; i < 3; i++) begin
      chk("ars_no_stale", fwd_if.out_valid, 0);
      cyc();
    end
    fwd_if.frame_valid = 1'b1;
    fwd_if.frame_data  = pack4(16'd60, 16'd61, 16'd62, 16'd63);   // G
    cyc();
    fwd_if.frame_valid = 1'b0;
    exp_q = '{16'd60, 16'd61, 16'd62, 16'd63};
    for (int i = 0; i < NE; i++) begin
      chk_fwd("ars_g", i, exp_q[i], i == NE - 1);
      cyc();
    end
    chk("ars_end_vld", fwd_if.out_valid, 0);
    chk("rev_err_idle", err_rev, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
